// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the DataMemory user port between
// the core data port (port 0) and a secondary agent (port 1).
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req0_ren,
    input  logic [WE_WIDTH-1:0]   i_req0_wen,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_data,
    output logic [DATA_WIDTH-1:0] o_req0_data,
    output logic                  o_req0_stall,
    input  logic                  i_req1_ren,
    input  logic [WE_WIDTH-1:0]   i_req1_wen,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_data,
    output logic [DATA_WIDTH-1:0] o_req1_data,
    output logic                  o_req1_stall,
    output logic                  o_mem_ren,
    output logic [WE_WIDTH-1:0]   o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_stall,
    output logic [1:0]            o_grant
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state, state_nx;
    logic   last, last_nx;
    logic   req0, req1;

    assign req0 = i_req0_ren | (|i_req0_wen);
    assign req1 = i_req1_ren | (|i_req1_wen);

    assign o_req0_data = i_mem_data;
    assign o_req1_data = i_mem_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            last  <= last_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        last_nx      = last;
        o_mem_ren    = 1'b0;
        o_mem_wen    = '0;
        o_mem_addr   = '0;
        o_mem_data   = '0;
        o_req0_stall = req0;
        o_req1_stall = req1;
        o_grant      = 2'b00;
        case (state)
            IDLE: begin
                // On a tie the port that was not served last wins
                unique case (1'b1)
                    req0 & (~req1 | last):  state_nx = GRANT0;
                    req1 & (~req0 | ~last): state_nx = GRANT1;
                    default:                state_nx = IDLE;
                endcase
            end
            GRANT0: begin
                o_mem_ren    = i_req0_ren;
                o_mem_wen    = i_req0_wen;
                o_mem_addr   = i_req0_addr;
                o_mem_data   = i_req0_data;
                o_req0_stall = req0 & i_mem_stall;
                o_grant      = 2'b01;
                if (!i_mem_stall) begin
                    state_nx = IDLE;
                    if (req0)
                        last_nx = 1'b0;
                end
            end
            GRANT1: begin
                o_mem_ren    = i_req1_ren;
                o_mem_wen    = i_req1_wen;
                o_mem_addr   = i_req1_addr;
                o_mem_data   = i_req1_data;
                o_req1_stall = req1 & i_mem_stall;
                o_grant      = 2'b10;
                if (!i_mem_stall) begin
                    state_nx = IDLE;
                    if (req1)
                        last_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a
// transaction-level owner/round-robin reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren[2];
    logic [3:0]  wen[2];
    logic [31:0] addr[2];
    logic [31:0] wdata[2];
    logic [31:0] mem_rdata;
    logic        mem_stall;

    logic [31:0] req0_data, req1_data;
    logic        req0_stall, req1_stall;
    logic        mem_ren;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  grant;

    int total = 0;
    int bad = 0;

    int          m_own;
    int          m_last;
    logic        e_stall[2];
    logic        done[2];
    logic [1:0]  obs_grant;
    logic        obs_s0, obs_s1, obs_ren;
    logic [3:0]  obs_wen;
    logic [31:0] obs_addr, obs_d0;
    logic [1:0]  gq[$];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req0_ren   (ren[0]),
        .i_req0_wen   (wen[0]),
        .i_req0_addr  (addr[0]),
        .i_req0_data  (wdata[0]),
        .o_req0_data  (req0_data),
        .o_req0_stall (req0_stall),
        .i_req1_ren   (ren[1]),
        .i_req1_wen   (wen[1]),
        .i_req1_addr  (addr[1]),
        .i_req1_data  (wdata[1]),
        .o_req1_data  (req1_data),
        .o_req1_stall (req1_stall),
        .o_mem_ren    (mem_ren),
        .o_mem_wen    (mem_wen),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .i_mem_data   (mem_rdata),
        .i_mem_stall  (mem_stall),
        .o_grant      (grant)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance it
    task automatic step();
        bit          r[2];
        logic [1:0]  eg;
        logic        eren;
        logic [3:0]  ewen;
        logic [31:0] ea, ed;
        #1;
        for (int n = 0; n < 2; n++)
            r[n] = ren[n] || (wen[n] != 4'd0);
        eg = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
        eren = 1'b0;
        ewen = 4'd0;
        ea = 32'd0;
        ed = 32'd0;
        if (m_own >= 0) begin
            eren = ren[m_own];
            ewen = wen[m_own];
            ea = addr[m_own];
            ed = wdata[m_own];
        end
        for (int n = 0; n < 2; n++) begin
            done[n] = (m_own == n) && r[n] && !mem_stall;
            e_stall[n] = r[n] && !((m_own == n) && !mem_stall);
        end
        chk("grant", {30'd0, grant}, {30'd0, eg});
        chk("stall0", {31'd0, req0_stall}, {31'd0, e_stall[0]});
        chk("stall1", {31'd0, req1_stall}, {31'd0, e_stall[1]});
        chk("mem_ren", {31'd0, mem_ren}, {31'd0, eren});
        chk("mem_wen", {28'd0, mem_wen}, {28'd0, ewen});
        chk("mem_addr", mem_addr, ea);
        chk("mem_data", mem_data, ed);
        chk("rdata0", req0_data, mem_rdata);
        chk("rdata1", req1_data, mem_rdata);
        obs_grant = grant;
        obs_s0 = req0_stall;
        obs_s1 = req1_stall;
        obs_ren = mem_ren;
        obs_wen = mem_wen;
        obs_addr = mem_addr;
        obs_d0 = req0_data;
        if (rst) begin
            m_own = -1;
            m_last = 1;
        end else if (m_own >= 0) begin
            if (!mem_stall) begin
                if (r[m_own])
                    m_last = m_own;
                m_own = -1;
            end
        end else if (r[0] && r[1]) begin
            m_own = 1 - m_last;
        end else if (r[0]) begin
            m_own = 0;
        end else if (r[1]) begin
            m_own = 1;
        end
        @(posedge clk);
        #1;
    endtask

    // Let each requester retire its transaction and go quiet
    task automatic drain();
        mem_stall = 1'b0;
        for (int i = 0; i < 30; i++) begin
            for (int n = 0; n < 2; n++)
                if (!e_stall[n]) begin
                    ren[n] = 1'b0;
                    wen[n] = 4'd0;
                end
            if (!ren[0] && wen[0] == 4'd0 && !ren[1] &&
                wen[1] == 4'd0 && m_own < 0)
                break;
            step();
        end
    endtask

    initial begin
        int cnt, hold, w, k;
        rst = 1'b1;
        mem_stall = 1'b0;
        mem_rdata = 32'd0;
        for (int n = 0; n < 2; n++) begin
            ren[n] = 1'b0;
            wen[n] = 4'd0;
            addr[n] = 32'd0;
            wdata[n] = 32'd0;
            e_stall[n] = 1'b0;
            done[n] = 1'b0;
        end
        @(posedge clk);
        #1;
        m_own = -1;
        m_last = 1;
        step();
        chk("reset_grant", {30'd0, obs_grant}, 32'd0);
        rst = 1'b0;
        step();

        // Single read on port 0, memory ready at once
        ren[0] = 1'b1;
        addr[0] = 32'h40;
        mem_rdata = 32'hDEADBEEF;
        cnt = 0;
        hold = 0;
        step();
        cnt += int'(obs_s0);
        hold += int'(obs_s1);
        step();
        cnt += int'(obs_s0);
        hold += int'(obs_s1);
        chk("t1_grant", {30'd0, obs_grant}, 32'd1);
        chk("t1_data", obs_d0, 32'hDEADBEEF);
        chk("t1_done", {31'd0, done[0]}, 32'd1);
        ren[0] = 1'b0;
        step();
        hold += int'(obs_s1);
        chk("t1_idle", {30'd0, obs_grant}, 32'd0);
        chk("t1_stall0_cyc", cnt, 1);
        chk("t1_stall1_cyc", hold, 0);

        // Port 1 write held off by the memory for 5 cycles
        wen[1] = 4'b0011;
        addr[1] = 32'h100;
        wdata[1] = 32'h12345678;
        cnt = 0;
        hold = 0;
        for (int i = 0; i < 7; i++) begin
            mem_stall = (i < 6);
            step();
            cnt += int'(obs_s1);
            if (obs_addr == 32'h100 && obs_wen == 4'b0011)
                hold++;
        end
        chk("t2_stall_cyc", cnt, 6);
        chk("t2_hold_cyc", hold, 6);
        chk("t2_done", {31'd0, done[1]}, 32'd1);
        drain();

        // Tie right after reset, both held continuously
        rst = 1'b1;
        step();
        rst = 1'b0;
        ren[0] = 1'b1;
        ren[1] = 1'b1;
        addr[0] = 32'h200;
        addr[1] = 32'h300;
        gq.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_grant != 2'b00)
                gq.push_back(obs_grant);
        end
        chk("alt_count", {31'd0, gq.size() >= 4}, 32'd1);
        for (int i = 0; i < 4; i++)
            if (i < gq.size())
                chk("alt_seq", {30'd0, gq[i]},
                    (i % 2 == 0) ? 32'd1 : 32'd2);
        drain();

        // Port 1 joins while port 0 streams reads
        ren[0] = 1'b1;
        addr[0] = 32'h44;
        for (int i = 0; i < 3; i++)
            step();
        ren[1] = 1'b1;
        addr[1] = 32'h88;
        w = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            w++;
            if (obs_grant == 2'b10)
                break;
        end
        chk("fair_wait", {31'd0, w <= 4}, 32'd1);
        drain();

        // Reset while port 1 is granted and stalled
        ren[1] = 1'b1;
        addr[1] = 32'h500;
        mem_stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            if (obs_grant == 2'b10)
                break;
        end
        chk("rst_pre_grant", {30'd0, obs_grant}, 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ren[0] = 1'b1;
        addr[0] = 32'h600;
        step();
        chk("rst_grant", {30'd0, obs_grant}, 32'd0);
        chk("rst_ren", {31'd0, obs_ren}, 32'd0);
        chk("rst_wen", {28'd0, obs_wen}, 32'd0);
        step();
        chk("rst_tie", {30'd0, obs_grant}, 32'd1);
        drain();

        // Port 0 idle while port 1 is stalled 10 cycles
        wen[1] = 4'b1111;
        addr[1] = 32'h700;
        mem_stall = 1'b1;
        cnt = 0;
        for (int i = 0; i < 11; i++) begin
            step();
            cnt += int'(obs_s0);
        end
        chk("idle_p0_stall", cnt, 0);
        drain();

        // Random traffic obeying the stall-hold protocol
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom % 64 == 0);
            mem_stall = ($urandom % 3 == 0);
            mem_rdata = $urandom;
            for (int n = 0; n < 2; n++)
                if (!e_stall[n] && ($urandom % 2 == 1)) begin
                    k = $urandom % 4;
                    ren[n] = (k == 1);
                    wen[n] = (k >= 2) ? 4'($urandom) : 4'd0;
                    addr[n] = $urandom & 32'hFFFF_FFFC;
                    wdata[n] = $urandom;
                end
            step();
        end
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single DataMemory user port (ren/wen/addr/data/stall) between two requesters: port 0, the RVCore data port (D_RE/D_WE/D_ADDR/WD_DATA/D_DATA/D_STALL), and port 1, a secondary agent such as a debug/DMA loader. It sits between the requesters and DataMemory in the user clock domain (o_clk/o_rst of DataMemory). It serialises whole transactions with round-robin fairness and drives each requester's stall so that the core's existing stall-hold protocol is preserved unchanged.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width on all ports
- WE_WIDTH, 4, byte write-enable width (DATA_WIDTH/8)
- clk  in  1  user clock, the DataMemory o_clk
- rst  in  1  reset, active-high, synchronous to clk; tied to DataMemory o_rst
- i_req0_ren / i_req1_ren  in  1  read request, ports 0/1
- i_req0_wen / i_req1_wen  in  WE_WIDTH  byte write enables, ports 0/1
- i_req0_addr / i_req1_addr  in  ADDR_WIDTH  address, 4-byte aligned
- i_req0_data / i_req1_data  in  DATA_WIDTH  write data
- o_req0_data / o_req1_data  out  DATA_WIDTH  read data, valid only in that port's completion cycle
- o_req0_stall / o_req1_stall  out  1  stall to each requester
- o_mem_ren  out  1  to DataMemory i_dmem_ren
- o_mem_wen  out  WE_WIDTH  to i_dmem_wen
- o_mem_addr  out  ADDR_WIDTH  to i_dmem_addr
- o_mem_data  out  DATA_WIDTH  to i_dmem_data
- i_mem_data  in  DATA_WIDTH  from o_dmem_data
- i_mem_stall  in  1  from o_dmem_stall
- o_grant  out  2  one-hot grant, debug/verification visibility

## Operation
- Port n is requesting when i_reqn_ren | (|i_reqn_wen). Requesters hold all request signals stable while their stall is high. A transaction completes in the first cycle in which the requester is granted and its stall is low.
- FSM states: IDLE, GRANT0, GRANT1. Round-robin pointer `last`: 0 = port 0 served last.
- IDLE: o_mem_ren=0, o_mem_wen=0. If exactly one port is requesting, go to its GRANT state. If both are requesting, grant the port not equal to `last`. With no request, stay in IDLE.
- GRANTn: o_mem_* forwards port n's signals combinationally. o_reqn_stall = i_mem_stall. When i_mem_stall=0, the cycle is the completion cycle: set `last`<=n and go to IDLE.
- Stall rule, any state: a port that is requesting and not in its completion cycle sees stall=1. A port that is not requesting sees stall=0.
- o_req0_data = o_req1_data = i_mem_data (broadcast). Requesters sample it only in their completion cycle.
- o_mem_addr and o_mem_data are 0 in IDLE.
- Protocol violation (granted port drops its request): forwarded ren/wen become 0. Once i_mem_stall=0 the FSM returns to IDLE with no completion and leaves `last` unchanged.
- o_grant = 2'b01 in GRANT0, 2'b10 in GRANT1, 2'b00 in IDLE.

## Timing
- Reset (rst=1 at a clk edge): state=IDLE, last=1 (port 0 wins the first tie), o_grant=0, o_mem_ren=0, o_mem_wen=0. Both stalls follow the stall rule (1 if requesting). Reset mid-transaction aborts it; DataMemory resets on the same rst.
- Minimum latency: request seen in IDLE at cycle 0; GRANT at cycle 1. If i_mem_stall=0 at cycle 1, completion occurs at cycle 1. So the minimum is 2 cycles per transaction with stall high for exactly 1 cycle.
- No back-to-back grants: at least one IDLE cycle separates transactions.
- Fairness bound: a waiting port is granted within one full transaction of the other port plus 2 cycles.
- A new request that arrives during GRANTn is considered only at the next IDLE.
- The pointer updates only on completion.

## Test plan
- Single read on port 0 only, with the memory returning stall=0 in its first cycle (data 0xDEADBEEF): o_req0_stall=1 for 1 cycle, o_req0_data=0xDEADBEEF in cycle 1, o_req1_stall=0 throughout, o_grant goes 01→00.
- Port 1 write, wen=4'b0011, addr 0x100, data 0x12345678, memory stall high for 5 cycles: o_mem_wen=0011, o_mem_addr=0x100 held for 6 cycles, o_req1_stall high for 6 cycles total and low on completion.
- Both ports request in the same cycle immediately after reset: port 0 is granted first and port 1 next. Repeat with both held continuously: grants alternate 01,10,01,10.
- Port 0 issues continuous back-to-back reads while port 1 raises a request: port 1 is granted immediately after port 0's current transaction and never waits more than one port-0 transaction.
- Assert rst during GRANT1 with memory stalled: the next cycle shows IDLE, o_grant=00, o_mem_ren=0, o_mem_wen=0. A subsequent tie grants port 0.
- Port 0 not requesting while port 1 is stalled for 10 cycles: o_req0_stall=0 every cycle, so the core pipeline is never blocked.
